// File: rtl/win_cmd_sched.sv
// Command scheduler for cursor_ctrl: debounces the board buttons, arbitrates them against
// the keyboard decoder and emits each move/zoom command as one pulse followed by a quiet gap.
`ifndef WIN_CMD_DEFS
`define WIN_CMD_DEFS
`define WIN_CTRL_CMD 6:0
`define M_UP    0
`define M_DOWN  1
`define M_LEFT  2
`define M_RIGHT 3
`define Z_IN    4
`define Z_OUT   5
`define M_MODE  6
`endif

module win_cmd_sched #(
  parameter int DEB_CYCLES    = 500_000,
  parameter int PULSE_LEN     = 4,
  parameter int GAP_LEN       = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [5:0]           btn,
  input  logic                 btn_mode,
  input  logic                 kbd_valid,
  input  logic [2:0]           kbd_code,
  output logic                 kbd_ready,
  output logic [`WIN_CTRL_CMD] win_ctrl_cmd,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] REP_FIRST  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_NEXT   = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Debounce: channel 6 is btn_mode, channels 0..5 are the move/zoom buttons.
  // ---------------------------------------------------------------------------
  logic [6:0]       raw;
  logic [6:0]       deb;
  logic [6:0]       deb_flip;
  logic [6:0]       rise;
  logic [CNT_W-1:0] deb_cnt [7];

  assign raw  = {btn_mode, btn};
  assign rise = deb_flip & raw;

  always_comb begin
    deb_flip = '0;
    for (int i = 0; i < 7; i++) begin
      deb_flip[i] = (raw[i] != deb[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb <= '0;
      for (int i = 0; i < 7; i++) deb_cnt[i] <= '0;
    end else begin
      deb <= deb ^ deb_flip;
      for (int i = 0; i < 7; i++) begin
        if ((raw[i] == deb[i]) || deb_flip[i]) deb_cnt[i] <= '0;
        else                                   deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold-to-repeat: the counter restarts on any debounced change, so a tick can
  // only belong to the single button that has been held since the last change.
  // ---------------------------------------------------------------------------
  logic [5:0]       mz;
  logic             one_hot;
  logic             rep_ok;
  logic             mz_change;
  logic             tick;
  logic             first_done;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic [5:0]       tick_vec;

  assign mz        = deb[5:0];
  assign one_hot   = (mz != 6'd0) && ((mz & (mz - 6'd1)) == 6'd0);
  assign rep_ok    = one_hot && (mz[5:4] == 2'b00);
  assign mz_change = |deb_flip[5:0];
  assign hold_nxt  = hold_cnt + 1'b1;
  assign tick      = !mz_change && rep_ok && (hold_nxt == (first_done ? REP_NEXT : REP_FIRST));
  assign tick_vec  = tick ? mz : 6'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt   <= '0;
      first_done <= 1'b0;
    end else if (mz_change || !one_hot) begin
      hold_cnt   <= '0;
      first_done <= 1'b0;
    end else if (tick) begin
      hold_cnt   <= '0;
      first_done <= 1'b1;
    end else begin
      hold_cnt   <= hold_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending button requests; a tick on an already pending bit merges into it.
  // ---------------------------------------------------------------------------
  logic [5:0] pend;
  logic [5:0] pend_clr;
  logic [2:0] btn_idx;
  logic       btn_req;

  assign btn_req = |pend;

  always_comb begin
    btn_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pend[i]) btn_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= (pend & ~pend_clr) | rise[5:0] | tick_vec;
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM. kbd_valid/kbd_ready: a keyboard command transfers on a clock
  // edge where both are high; kbd_ready is only offered in IDLE when the keyboard
  // would win arbitration, and a code dropped before that edge is never seen.
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_nxt;
  logic             rr;
  logic             rr_nxt;
  logic [2:0]       cmd_idx;
  logic [2:0]       idx_nxt;
  logic             kbd_toggle;
  logic             mode_lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      rr        <= 1'b0;
      cmd_idx   <= 3'd0;
      mode_lvl  <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      rr        <= rr_nxt;
      cmd_idx   <= idx_nxt;
      mode_lvl  <= mode_lvl ^ rise[6] ^ kbd_toggle;
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase_cnt;
    rr_nxt     = rr;
    idx_nxt    = cmd_idx;
    pend_clr   = 6'd0;
    kbd_ready  = 1'b0;
    kbd_toggle = 1'b0;
    case (state)
      IDLE: begin
        kbd_ready = kbd_valid && (!btn_req || rr);
        if (btn_req && kbd_valid) rr_nxt = !rr;
        if (kbd_ready) begin
          if (kbd_code <= 3'd5) begin
            idx_nxt   = kbd_code;
            state_nxt = PULSE;
            phase_nxt = '0;
          end else if (kbd_code == 3'd6) begin
            kbd_toggle = 1'b1;
          end
        end else if (btn_req) begin
          idx_nxt   = btn_idx;
          pend_clr  = 6'b1 << btn_idx;
          state_nxt = PULSE;
          phase_nxt = '0;
        end
      end
      PULSE: begin
        if (phase_cnt == PULSE_LAST) begin
          state_nxt = GAP;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + 1'b1;
        end
      end
      GAP: begin
        if (phase_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Run mode forces window moves without disturbing the stored toggle level.
  always_comb begin
    win_ctrl_cmd          = '0;
    win_ctrl_cmd[5:0]     = (state == PULSE) ? (6'b1 << cmd_idx) : 6'd0;
    win_ctrl_cmd[`M_MODE] = mode_lvl | mode;
  end

  assign busy = (state != IDLE);

endmodule
